// File: rtl/rr_thermo_arbiter.sv
// Round-robin, burst-locking arbiter: one downstream channel shared by NUM_REQ requesters.
// The grant is held from the first beat until the owner's last beat or the beat cap.
module rr_thermo_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic                       out_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       xfer,
  output logic                       proto_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e             st_q, st_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] ptr, hi_mask, masked, cand, winner;
  logic               owner_req, cap_hit, rel;

  // Prefix-OR: every bit at and above the lowest set bit.
  function automatic logic [NUM_REQ-1:0] thermo(input logic [NUM_REQ-1:0] x);
    logic [NUM_REQ-1:0] t;
    t[0] = x[0];
    for (int i = 1; i < NUM_REQ; i++) begin
      t[i] = t[i-1] | x[i];
    end
    return t;
  endfunction

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign proto_err   = err_q;
  assign owner_req   = |(req & grant_q);
  assign xfer        = grant_valid & out_ready & owner_req;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) grant_idx = grant_idx | IdxW'(i);
    end
  end

  always_comb begin
    cap_hit = (MAX_BEATS != 0) && (cnt_q == CNT_W'(MAX_BEATS - 1));
    rel     = xfer & ((|(req_last & grant_q)) | cap_hit);
    // On release the pointer moves to the current owner before re-arbitrating.
    ptr     = rel ? grant_q : last_q;
    hi_mask = thermo(ptr << 1);
    masked  = req & hi_mask;
    cand    = (|masked) ? masked : req;
    winner  = cand & ~(thermo(cand) << 1);
  end

  always_comb begin
    st_d    = st_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (st_q)
      StIdle: begin
        if (|req) begin
          grant_d = winner;
          st_d    = StLocked;
          cnt_d   = '0;
        end
      end
      StLocked: begin
        if (!owner_req) err_d = 1'b1;
        if (rel) begin
          last_d = grant_q;
          cnt_d  = '0;
          if (|req) begin
            grant_d = winner;
          end else begin
            grant_d = '0;
            st_d    = StIdle;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d    = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      grant_q <= '0;
      last_q  <= {1'b1, {(NUM_REQ-1){1'b0}}};
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

// File: doc/rr_thermo_arbiter.md
Name: rr_thermo_arbiter

Overview:
- Round-robin, burst-locking arbiter that shares one downstream channel between NUM_REQ requesters.
- Priority rotation uses the CommonUtils UIntToThermo prefix-OR, which sets every bit at and above the lowest set bit.
- Sits in front of any shared datapath resource: bus port, memory port or shared pipeline.
- Holds a grant from its first beat until the requester's last beat, or until a burst-length cap forces release.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..32 (limited by the UIntToThermo width).
- MAX_BEATS, 16, forced release after this many transferred beats in one grant; 0 disables the cap.
- CNT_W, $clog2(MAX_BEATS+1), width of the beat counter (derived).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous and active-low.
- req  input  NUM_REQ  per-requester request/valid.
- req_last  input  NUM_REQ  per-requester last-beat flag; qualified by req.
- out_ready  input  1  downstream accepts the current beat.
- grant  output  NUM_REQ  registered one-hot grant.
- grant_valid  output  1  OR of grant.
- grant_idx  output  $clog2(NUM_REQ)  binary index of the granted requester.
- xfer  output  1  beat transferred this cycle: grant_valid & out_ready & |(req & grant).
- proto_err  output  1  sticky flag: granted requester dropped req before its last beat.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - grant=0, grant_valid=0, grant_idx=0, proto_err=0.
  - State IDLE; priority pointer last_oh = one-hot bit NUM_REQ-1, so requester 0 has highest priority first.
  - Beat counter = 0.
  - Reset mid-burst abandons the burst immediately.
- Arbitration (combinational):
  - hi_mask = UIntToThermo(last_oh<<1), i.e. bits strictly above the last winner.
  - masked = req & hi_mask.
  - cand = masked if masked != 0, else req.
  - winner_oh = cand & ~(UIntToThermo(cand)<<1), i.e. the lowest set bit.
- State IDLE:
  - If |req: next cycle grant=winner_oh, state LOCKED, counter=0.
  - Otherwise stay IDLE.
  - Latency from req to grant is one cycle.
- State LOCKED:
  - grant is held constant.
  - On each xfer the counter increments.
  - Release condition: xfer & ((req_last & grant)!=0 | (MAX_BEATS!=0 & counter==MAX_BEATS-1)).
  - On release: last_oh<=grant, then re-arbitrate in the same cycle using the updated pointer and current req (back-to-back, no bubble):
    - If any req (the releasing requester included), load the new winner and stay LOCKED with counter=0.
    - Otherwise grant<=0 and go to IDLE.
  - The releasing requester is re-granted only if no other requester is active.
- Without a release condition, grant holds even if out_ready stays low indefinitely.
- Granted requester deasserts req while LOCKED:
  - No xfer occurs; grant is held; proto_err<=1.
  - proto_err clears only on reset.
- Simultaneous events:
  - req_last and cap hit on the same beat give one release, not two.
  - Requests arriving during a lock are only sampled at release.
- grant_idx is the encode of the registered grant; it is 0 when grant_valid=0.
- Stated invariant: grant is always zero or one-hot.

Test Plan:
- Reset, then req=4'b1111, req_last=4'b1111, out_ready=1 held → grant sequence 0001,0010,0100,1000,0001 on consecutive cycles after the first-grant latency; xfer=1 every cycle.
- req=4'b0100 alone with req_last low for 3 beats then high → grant=0100 for 4 xfers; IDLE afterwards; grant_valid=0 the next cycle.
- MAX_BEATS=4, req[1] continuous with req_last never set, req[2] also asserted → grant 0010 for exactly 4 xfers, then 0100.
- Grant on req[3] with out_ready=0 for 10 cycles → grant=1000 held; xfer=0; counter stays 0; no rotation.
- Granted req[0] dropped mid-burst → proto_err=1 next cycle and stays 1; grant stays 0001 until req[0] returns and completes its last beat.
- Assert rst_n=0 while LOCKED on requester 2 → next cycle grant=0; after release of reset with req=4'b0101, the first grant is 0001.
